fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It holds the F-stage program counter and drives the combinational instruction memory. It resolves next-PC redirects requested by the D stage (branch, J/JAL, JR) with a single architectural delay slot. It registers the fetched word into the IF/ID pipeline register, with stall, flush and address-error handling.

## Interface
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_WORDS, 4096, instruction-memory depth in words. The legal fetch range is IM_BASE to IM_BASE+4*IM_WORDS-4.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately.
- stall  in  1  hold PC and IF/ID this cycle.
- flush  in  1  load a bubble into IF/ID this cycle.
- npc_sel  in  2  D-stage redirect request: 0 sequential, 1 branch, 2 jump (J/JAL), 3 register (JR).
- br_taken  in  1  branch condition result from D. Only meaningful when npc_sel=1.
- imm16  in  16  D-stage branch offset in words, sign-extended.
- instr_index  in  26  D-stage jump index.
- jr_target  in  32  forwarded rs value from D.
- im_addr  out  32  byte address to instruction memory (combinational).
- im_data  in  32  instruction word from instruction memory (combinational read).
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, the link value for JAL.
- valid_d  out  1  IF/ID holds a real instruction.
- addr_err  out  1  sticky fetch-address error.
- fetch_cnt  out  32  count of valid instructions loaded into IF/ID.

## Operation
- State: pc_f, IF/ID register (instr_d, pc_d, valid_d), addr_err, fetch_cnt.
- Fetch address is legal when pc_f[1:0]==0 and pc_f lies in the legal range.
  - Legal: im_addr=pc_f.
  - Illegal: im_addr=IM_BASE; the word captured into IF/ID is 32'h0 with valid_d=0; addr_err is set and stays set until reset.
- A redirect is effective only when valid_d=1. When valid_d=0, npc_sel is treated as 0.
- Next PC, when not stalled:
  - npc_sel=0, or npc_sel=1 with br_taken=0: pc_f+4.
  - npc_sel=1 with br_taken=1: pc_d+4+(sext(imm16)<<2). Arithmetic is 32-bit modulo.
  - npc_sel=2: {pc_d[31:28]+carry-adjusted, i.e. (pc_d+4)[31:28], instr_index, 2'b00}.
  - npc_sel=3: jr_target, loaded unmodified. Misalignment is caught at the next fetch.
- Delay slot: while a redirect sits in D, pc_f equals pc_d+4. That delay-slot instruction is captured into IF/ID normally and is never squashed by the redirect.
- IF/ID update:
  - stall=1: hold.
  - Else flush=1: instr_d=0, valid_d=0, pc_d=pc_f.
  - Else: instr_d=fetched word, pc_d=pc_f, valid_d=legal.
  - The flush bubble takes priority over stall for IF/ID only. With stall=1 and flush=1, pc_f holds and IF/ID is cleared as a bubble.
- fetch_cnt increments by 1 on each edge where IF/ID loads valid_d=1. It wraps from 32'hFFFF_FFFF to 0.
- pc8_d = pc_d+8, computed combinationally.

## Timing
- Reset (reset=0, asynchronous): pc_f=PC_RESET, instr_d=0, pc_d=0, valid_d=0, addr_err=0, fetch_cnt=0. pc8_d consequently reads 8.
- Reset asserted mid-operation takes effect without waiting for clk and discards any pending redirect.
- im_addr follows pc_f with zero cycles of latency. instr_d and pc_d appear at the first edge after pc_f is presented.
- After reset release, the first edge loads instr_d=mem[0] and pc_d=PC_RESET.
- Redirect latency: the request is sampled in the cycle the branch sits in D. The target is in pc_f after the next edge and in instr_d one edge later.
- While stall=1, redirect inputs are ignored. D holds the branch, so the request is re-presented after the stall ends.
- The register-to-register path has no combinational loop. npc logic depends only on registered pc_d/pc_f and D inputs.

## Test plan
- Reset and sequential fetch:
  - Stimulus: memory words 0..3 = 0x11,0x22,0x33,0x44; release reset.
  - Required: instr_d/pc_d step through (0x11,0x3000), (0x22,0x3004), (0x33,0x3008), (0x44,0x300C). fetch_cnt=4 and pc8_d=0x3014 after the fourth edge.
- Taken branch with delay slot:
  - Stimulus: branch at 0x3008 with imm16=16'hFFFD, br_taken=1.
  - Required: 0x300C (delay slot) is loaded into IF/ID, then pc_d=0x3000, since 0x300C-12=0x3000.
- Jump, JR and out-of-range error:
  - Stimulus: J with instr_index=0x0C10 at 0x3000; then JR with jr_target=0x7000.
  - Required: after the delay slot, pc_d=0x3040. After JR, im_addr=0x3000, instr_d=0, valid_d=0, addr_err=1 and stays 1.
- Stall and flush:
  - Stimulus: stall=1 for 3 cycles mid-stream; then stall=1 with flush=1 for 1 cycle.
  - Required: pc_f, instr_d and fetch_cnt frozen during the stall. During stall+flush, valid_d=0, instr_d=0 and pc_f held. The next edge resumes at the held pc_f.
- Async reset mid-stream:
  - Stimulus: drop reset between edges while a branch is pending in D.
  - Required: all outputs take their reset values immediately. The first post-reset fetch is 0x3000, not the branch target.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: F-stage PC, instruction-memory addressing, next-PC
// redirect with one delay slot, and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [1:0]  i_npc_sel,
  input  logic        i_br_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_im_addr_c,
  input  logic [31:0] i_im_data,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc8_d_c,
  output logic        o_valid_d,
  output logic        o_addr_err,
  output logic [31:0] o_fetch_cnt
);

  localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_addr_err;
  logic [31:0] r_fetch_cnt;

  logic        w_legal;
  logic [31:0] w_fetch_word;
  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_pc_d_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;
  npc_sel_e    w_sel;

  // Fetch legality: word aligned and inside the instruction-memory window.
  always_comb begin
    w_legal      = (r_pc_f[1:0] == 2'b00) && (r_pc_f >= IM_BASE) && (r_pc_f <= IM_LAST);
    o_im_addr_c  = w_legal ? r_pc_f : IM_BASE;
    w_fetch_word = w_legal ? i_im_data : 32'h0;
  end

  // Next-PC select; a bubble in D can never redirect.
  always_comb begin
    w_pc_f_plus4 = r_pc_f + 32'd4;
    w_pc_d_plus4 = r_pc_d + 32'd4;
    w_br_off     = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    w_sel        = r_valid_d ? npc_sel_e'(i_npc_sel) : NPC_SEQ;
    w_npc        = w_pc_f_plus4;
    case (w_sel)
      NPC_BR:  w_npc = i_br_taken ? (w_pc_d_plus4 + w_br_off) : w_pc_f_plus4;
      NPC_J:   w_npc = {w_pc_d_plus4[31:28], i_instr_index, 2'b00};
      NPC_JR:  w_npc = i_jr_target;
      default: w_npc = w_pc_f_plus4;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_f <= PC_RESET;
    end else if (!i_stall) begin
      r_pc_f <= w_npc;
    end
  end

  // IF/ID register; a flush bubble wins over stall here only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr_d <= 32'h0;
      r_pc_d    <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (i_flush) begin
      r_instr_d <= 32'h0;
      r_pc_d    <= r_pc_f;
      r_valid_d <= 1'b0;
    end else if (!i_stall) begin
      r_instr_d <= w_fetch_word;
      r_pc_d    <= r_pc_f;
      r_valid_d <= w_legal;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_err  <= 1'b0;
      r_fetch_cnt <= 32'h0;
    end else begin
      if (!w_legal) begin
        r_addr_err <= 1'b1;
      end
      if (!i_flush && !i_stall && w_legal) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign o_instr_d   = r_instr_d;
  assign o_pc_d      = r_pc_d;
  assign o_pc8_d_c   = r_pc_d + 32'd8;
  assign o_valid_d   = r_valid_d;
  assign o_addr_err  = r_addr_err;
  assign o_fetch_cnt = r_fetch_cnt;

endmodule
